// File: rtl/fade_pkg.sv
// Shared segment definitions and level shaping for the RGB fade engine.
// Levels follow a six-segment cycle: rise, high, high, fall, low, low.
package fade_pkg;

  localparam int NUM_SEGS = 6;

  typedef logic [2:0]  seg_t;
  typedef logic [31:0] word_t;

  localparam seg_t SEG_RISE         = 3'd0;
  localparam seg_t SEG_HOLD_HI_LAST = 3'd2;
  localparam seg_t SEG_FALL         = 3'd3;
  localparam seg_t SEG_LOW_LAST     = 3'd5;

  // Callers pass their own full-scale value and truncate the result to their width.
  function automatic word_t level_of(input seg_t seg, input word_t step, input word_t max);
    word_t lvl;
    case (seg)
      SEG_RISE:                lvl = step;
      3'd1, SEG_HOLD_HI_LAST:  lvl = max;
      SEG_FALL:                lvl = max - step;
      default:                 lvl = 32'd0;
    endcase
    return lvl;
  endfunction

  function automatic seg_t next_seg(input seg_t seg);
    seg_t nxt;
    if (seg == SEG_LOW_LAST) begin
      nxt = SEG_RISE;
    end else begin
      nxt = seg + 3'd1;
    end
    return nxt;
  endfunction

  function automatic seg_t reset_seg_of(input int idx);
    return seg_t'((2 * idx) % NUM_SEGS);
  endfunction

endpackage

// File: rtl/fade_pwm_channel.sv
// One PWM channel: owns its segment register, level/duty shaping and output comparator.
// Define GAMMA_EN to square the level (duty = level*level >> W) for a perceptual curve.
module fade_pwm_channel
  import fade_pkg::*;
#(
  parameter int PWM_WIDTH = 8,
  parameter bit REPORT    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_restart,
  input  seg_t                 reset_seg,
  input  logic [PWM_WIDTH-1:0] step,
  input  logic                 tick_wrap,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 period_end,
  output logic                 pwm
);

  typedef logic [PWM_WIDTH-1:0] lvl_t;
  localparam lvl_t MAX_LVL = {PWM_WIDTH{1'b1}};

  seg_t seg_r;
  lvl_t level_s;
  lvl_t duty_s;
  logic pwm_r;

  // segment position, advanced once per step-counter wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= reset_seg;
    end else if (sync_restart) begin
      seg_r <= reset_seg;
    end else if (tick_wrap) begin
      seg_r <= next_seg(seg_r);
    end else begin
      seg_r <= seg_r;
    end
  end

  // level from segment and shared step
  always_comb begin
    level_s = lvl_t'(level_of(seg_r, word_t'(step), word_t'(MAX_LVL)));
  end

`ifdef GAMMA_EN
  logic [2*PWM_WIDTH-1:0] prod_s;

  // squared level keeps the top W bits of the 2W-bit product
  always_comb begin
    prod_s = {{PWM_WIDTH{1'b0}}, level_s} * {{PWM_WIDTH{1'b0}}, level_s};
    duty_s = lvl_t'(prod_s >> PWM_WIDTH);
  end
`else
  // linear duty
  always_comb begin
    duty_s = level_s;
  end
`endif

  // only the reference channel reports the end of its full period
  always_comb begin
    if (REPORT) begin
      period_end = tick_wrap && (seg_r == SEG_LOW_LAST);
    end else begin
      period_end = 1'b0;
    end
  end

  // registered comparator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= (pwm_cnt < duty_s);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/rgb_fade_engine.sv
// Multi-channel PWM hue fader: shared PWM counter, rate prescaler and step counter
// feeding NUM_CH phase-offset channels. Optional GAMMA_EN selects squared duty.
module rgb_fade_engine
  import fade_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int PWM_WIDTH    = 8,
  parameter int PWM_INTERVAL = 1200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        rate_sel,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              cycle_done
);

  localparam int PS_W = $clog2(PWM_INTERVAL * 8);

  typedef logic [PS_W-1:0]      ps_t;
  typedef logic [PWM_WIDTH-1:0] lvl_t;

  localparam lvl_t MAX_LVL   = {PWM_WIDTH{1'b1}};
  localparam lvl_t STEP_LAST = MAX_LVL - lvl_t'(1'b1);
  localparam lvl_t LVL_ONE   = lvl_t'(1'b1);
  localparam ps_t  PS_ONE    = ps_t'(1'b1);

  lvl_t              pwm_cnt_r;
  lvl_t              step_r;
  ps_t               presc_r;
  ps_t               terminal_s;
  logic              tick_s;
  logic              tick_wrap_s;
  logic              cycle_done_r;
  logic [NUM_CH-1:0] pwm_s;
  logic [NUM_CH-1:0] period_end_s;

  // free-running PWM counter, unaffected by en and sync_restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
    end
  end

  // tick generation; >= lets a shortened period fire immediately
  always_comb begin
    terminal_s  = ps_t'((PWM_INTERVAL << rate_sel) - 32'sd1);
    tick_s      = 1'b0;
    tick_wrap_s = 1'b0;
    if (en && !sync_restart && (presc_r >= terminal_s)) begin
      tick_s      = 1'b1;
      tick_wrap_s = (step_r == STEP_LAST);
    end else begin
      tick_s      = 1'b0;
      tick_wrap_s = 1'b0;
    end
  end

  // prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (sync_restart) begin
      presc_r <= '0;
    end else if (en) begin
      if (tick_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PS_ONE;
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  // shared step counter, 0..MAX-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r <= '0;
    end else if (sync_restart) begin
      step_r <= '0;
    end else if (tick_wrap_s) begin
      step_r <= '0;
    end else if (tick_s) begin
      step_r <= step_r + LVL_ONE;
    end else begin
      step_r <= step_r;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      fade_pwm_channel #(
        .PWM_WIDTH (PWM_WIDTH),
        .REPORT    (gi == 0)
      ) u_ch (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_restart (sync_restart),
        .reset_seg    (reset_seg_of(gi)),
        .step         (step_r),
        .tick_wrap    (tick_wrap_s),
        .pwm_cnt      (pwm_cnt_r),
        .period_end   (period_end_s[gi]),
        .pwm          (pwm_s[gi])
      );
    end
  endgenerate

  // end-of-period pulse; tick is already masked by sync_restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_done_r <= 1'b0;
    end else begin
      cycle_done_r <= |period_end_s;
    end
  end

  assign pwm_out    = pwm_s;
  assign cycle_done = cycle_done_r;

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Bench for rgb_fade_engine (NUM_CH=3, W=4, interval 2): per-cycle scoreboard plus phase table.
module tb_rgb_fade_engine;

  localparam int NCH      = 3;
  localparam int W        = 4;
  localparam int INTERVAL = 2;
  localparam int MAXV     = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [1:0]     rate_sel = 2'd0;
  logic           sync_restart = 1'b0;
  logic [NCH-1:0] pwm_out;
  logic           cycle_done;

  always #5 clk = ~clk;

  rgb_fade_engine #(
    .NUM_CH       (NCH),
    .PWM_WIDTH    (W),
    .PWM_INTERVAL (INTERVAL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .rate_sel     (rate_sel),
    .sync_restart (sync_restart),
    .pwm_out      (pwm_out),
    .cycle_done   (cycle_done)
  );

  typedef struct packed {
    logic [NCH-1:0] pwm;
    logic           cd;
  } exp_t;

  typedef struct {
    string      name;
    bit         en;
    logic [1:0] rate;
    bit         restart;
    int         n;
    bit         chk_hi;
    bit         chk_cd;
    int         lv0;
    int         lv1;
    int         lv2;
    int         cd;
  } phase_t;

  exp_t   sb_q[$];
  phase_t ph_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt, m_presc, m_step;
  int m_seg[NCH];
  int hi_cnt[NCH];
  int cd_cnt;

  function automatic int gam(input int l);
`ifdef GAMMA_EN
    return (l * l) >> W;
`else
    return l;
`endif
  endfunction

  function automatic int duty_of(input int seg, input int step);
    int lvl;
    if (seg == 0) lvl = step;
    else if (seg <= 2) lvl = MAXV;
    else if (seg == 3) lvl = MAXV - step;
    else lvl = 0;
    return gam(lvl);
  endfunction

  task automatic model_home();
    m_presc = 0;
    m_step  = 0;
    for (int i = 0; i < NCH; i++) m_seg[i] = (2 * i) % 6;
  endtask

  // One clock: predict outputs from current model state and inputs, clock, compare.
  task automatic cycle();
    exp_t e;
    exp_t got;
    bit   tick;
    for (int ch = 0; ch < NCH; ch++) e.pwm[ch] = (m_cnt < duty_of(m_seg[ch], m_step));
    tick = en && !sync_restart && (m_presc >= ((INTERVAL << rate_sel) - 1));
    e.cd = tick && (m_step == MAXV - 1) && (m_seg[0] == 5);
    if (!rst_n) e = '0;
    sb_q.push_back(e);
    if (!rst_n) begin
      m_cnt = 0;
      model_home();
    end else begin
      m_cnt = (m_cnt + 1) % (MAXV + 1);
      if (sync_restart) begin
        model_home();
      end else if (tick) begin
        m_presc = 0;
        if (m_step == MAXV - 1) begin
          m_step = 0;
          for (int ch = 0; ch < NCH; ch++) m_seg[ch] = (m_seg[ch] + 1) % 6;
        end else begin
          m_step++;
        end
      end else if (en) begin
        m_presc++;
      end
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    got.pwm = pwm_out;
    got.cd  = cycle_done;
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL sb_cycle t=%0t: got pwm=%b cd=%b, want pwm=%b cd=%b",
               $time, got.pwm, got.cd, e.pwm, e.cd);
    end
    for (int ch = 0; ch < NCH; ch++) hi_cnt[ch] += int'(pwm_out[ch]);
    cd_cnt += int'(cycle_done);
  endtask

  task automatic add(input string nm, input bit e, input logic [1:0] r, input bit rs, input int n,
                     input bit ch, input bit cc, input int l0, input int l1, input int l2, input int c);
    phase_t p;
    p.name = nm; p.en = e; p.rate = r; p.restart = rs; p.n = n;
    p.chk_hi = ch; p.chk_cd = cc; p.lv0 = l0; p.lv1 = l1; p.lv2 = l2; p.cd = c;
    ph_q.push_back(p);
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int lv[NCH];

    //   name            en rate rs   n  hi cd lv0 lv1 lv2 cd
    add("idle_reset",    0, 0,  0,  16, 1, 1,  0, 15, 0, 0);
    add("ramp_run",      1, 0,  0,  10, 0, 0,  0,  0, 0, 0);
    add("ramp_5",        0, 0,  0,  16, 1, 1,  5, 15, 0, 0);
    add("run_to_7",      1, 0,  0,   4, 0, 0,  0,  0, 0, 0);
    add("freeze_100",    0, 0,  0, 100, 0, 0,  0,  0, 0, 0);
    add("frozen_7",      0, 0,  0,  16, 1, 1,  7, 15, 0, 0);
    add("resume_2",      1, 0,  0,   2, 0, 0,  0,  0, 0, 0);
    add("level_8",       0, 0,  0,  16, 1, 1,  8, 15, 0, 0);
    add("restart_mid",   0, 0,  1,   1, 0, 0,  0,  0, 0, 0);
    add("after_restart", 0, 0,  0,  16, 1, 1,  0, 15, 0, 0);
    add("full_period",   1, 0,  0, 180, 0, 1,  0,  0, 0, 1);
    add("period_home",   0, 0,  0,  16, 1, 1,  0, 15, 0, 0);
    add("restart_a",     1, 0,  1,   1, 0, 0,  0,  0, 0, 0);
    add("almost_period", 1, 0,  0, 179, 0, 1,  0,  0, 0, 0);
    add("restart_wrap",  1, 0,  1,   1, 0, 1,  0,  0, 0, 0);
    add("wrap_home",     0, 0,  0,  16, 1, 1,  0, 15, 0, 0);
    add("restart_r3",    1, 3,  1,   1, 0, 0,  0,  0, 0, 0);
    add("slow_64",       1, 3,  0,  64, 0, 0,  0,  0, 0, 0);
    add("slow_level_4",  0, 3,  0,  16, 1, 1,  4, 15, 0, 0);
    add("restart_r3b",   1, 3,  1,   1, 0, 0,  0,  0, 0, 0);
    add("presc_to_10",   1, 3,  0,  10, 0, 0,  0,  0, 0, 0);
    add("rate_drop",     1, 0,  0,  11, 0, 0,  0,  0, 0, 0);
    add("fast_level_6",  0, 0,  0,  16, 1, 1,  6, 15, 0, 0);

    m_cnt = 0;
    model_home();

    // reset held for 5 clocks
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++;
      if (pwm_out !== 3'b000 || cycle_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out: got pwm=%b cd=%b want pwm=000 cd=0", pwm_out, cycle_done);
      end
    end
    rst_n = 1'b1;

    foreach (ph_q[k]) begin
      en           = ph_q[k].en;
      rate_sel     = ph_q[k].rate;
      sync_restart = ph_q[k].restart;
      for (int ch = 0; ch < NCH; ch++) hi_cnt[ch] = 0;
      cd_cnt = 0;
      for (int c = 0; c < ph_q[k].n; c++) begin
        cycle();
        sync_restart = 1'b0;
      end
      if (ph_q[k].chk_hi) begin
        lv[0] = ph_q[k].lv0;
        lv[1] = ph_q[k].lv1;
        lv[2] = ph_q[k].lv2;
        for (int ch = 0; ch < NCH; ch++)
          check_int($sformatf("%s hi_ch%0d", ph_q[k].name, ch), hi_cnt[ch], gam(lv[ch]));
      end
      if (ph_q[k].chk_cd) check_int($sformatf("%s cycle_done_pulses", ph_q[k].name), cd_cnt, ph_q[k].cd);
    end

    // asynchronous reset mid-run must clear outputs without a clock edge
    en = 1'b1;
    rate_sel = 2'd0;
    for (int i = 0; i < 20; i++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== 3'b000 || cycle_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got pwm=%b cd=%b want pwm=000 cd=0", pwm_out, cycle_done);
    end
    m_cnt = 0;
    model_home();
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;
    for (int ch = 0; ch < NCH; ch++) hi_cnt[ch] = 0;
    for (int i = 0; i < 16; i++) cycle();
    check_int("post_async_ch1", hi_cnt[1], gam(15));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
